// File: rtl/cpu_pkg.sv
// Shared definitions for the writeback/commit stage: field widths,
// exception codes and the per-lane control payload.
package cpu_pkg;

  localparam int CPU_DATA_W    = 32;
  localparam int CPU_CSR_NUM_W = 14;
  localparam int CPU_ECODE_W   = 6;
  localparam int CPU_ESUB_W    = 9;
  localparam int RF_ADDR_W     = 5;

  // Exception codes used by the core
  localparam logic [CPU_ECODE_W-1:0] ECODE_SYS = 6'h0b;
  localparam logic [CPU_ECODE_W-1:0] ECODE_ADE = 6'h08;
  localparam logic [CPU_ECODE_W-1:0] ECODE_ALE = 6'h09;
  localparam logic [CPU_ECODE_W-1:0] ECODE_INE = 6'h0d;

  // Narrow per-lane control bits; wide data fields live in separate arrays
  // so they can follow the module's width parameters.
  typedef struct packed {
    logic                 rf_we;
    logic                 csr_re;
    logic                 csr_we;
    logic                 exc;
    logic                 ertn;
    logic [RF_ADDR_W-1:0] rf_waddr;
  } lane_ctrl_t;

endpackage

// File: rtl/lane_pick.sv
// Lowest-set-bit priority encoder: selects the oldest pending lane.
module lane_pick #(
  parameter int LANES = 2,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] req,
  output logic [LANES-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic found;

  // Scan from lane 0 upwards and keep the first requester only
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane writeback/commit stage: latches a bundle from MEM and retires
// its valid lanes in order, one per cycle, with precise exceptions/ERTN.
module wb_commit_stage
  import cpu_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int DATA_W    = CPU_DATA_W,
  parameter int CSR_NUM_W = CPU_CSR_NUM_W,
  parameter int ECODE_W   = CPU_ECODE_W,
  parameter int ESUB_W    = CPU_ESUB_W
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   wb_allowin,
  input  logic                   mem_wb_valid,
  input  logic [LANES-1:0]       mem_lane_valid,
  input  logic [LANES*DATA_W-1:0] mem_pc,
  input  logic [LANES-1:0]       mem_rf_we,
  input  logic [LANES-1:0]       mem_csr_re,
  input  logic [LANES*5-1:0]     mem_rf_waddr,
  input  logic [LANES*DATA_W-1:0] mem_rf_wdata,
  input  logic [LANES-1:0]       mem_exc,
  input  logic [LANES-1:0]       mem_ertn,
  input  logic [LANES-1:0]       mem_csr_we,
  input  logic [LANES*ECODE_W-1:0] mem_ecode,
  input  logic [LANES*ESUB_W-1:0]  mem_esubcode,
  input  logic [LANES*DATA_W-1:0]  mem_badv,
  input  logic [LANES*CSR_NUM_W-1:0] mem_csr_num,
  input  logic [LANES*DATA_W-1:0]  mem_csr_wmask,
  input  logic [LANES*DATA_W-1:0]  mem_csr_wvalue,
  output logic [CSR_NUM_W-1:0]   csr_num,
  input  logic [DATA_W-1:0]      csr_rvalue,
  output logic                   csr_we,
  output logic [DATA_W-1:0]      csr_wmask,
  output logic [DATA_W-1:0]      csr_wvalue,
  output logic                   exc_signal,
  output logic                   ertn_signal,
  output logic [DATA_W-1:0]      wb_pc,
  output logic [DATA_W-1:0]      wb_badv,
  output logic [ECODE_W-1:0]     wb_ecode,
  output logic [ESUB_W-1:0]      wb_esubcode,
  output logic                   wb_rf_we,
  output logic [4:0]             wb_rf_waddr,
  output logic [DATA_W-1:0]      wb_rf_wdata,
  output logic [DATA_W-1:0]      debug_wb_pc,
  output logic [3:0]             debug_wb_rf_we,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata,
  output logic [63:0]            retire_cnt
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(LANES + 1) + 1;

  logic [LANES-1:0]     pending_reg;
  lane_ctrl_t           ctrl_reg     [LANES];
  logic [DATA_W-1:0]    pc_reg       [LANES];
  logic [DATA_W-1:0]    wdata_reg    [LANES];
  logic [DATA_W-1:0]    badv_reg     [LANES];
  logic [DATA_W-1:0]    wmask_reg    [LANES];
  logic [DATA_W-1:0]    wvalue_reg   [LANES];
  logic [ECODE_W-1:0]   ecode_reg    [LANES];
  logic [ESUB_W-1:0]    esub_reg     [LANES];
  logic [CSR_NUM_W-1:0] csr_num_reg  [LANES];
  logic [63:0]          retire_cnt_reg;
  logic [DATA_W-1:0]    last_pc_reg;

  logic [LANES-1:0] cur_onehot;
  logic [IDX_W-1:0] cur_idx;
  logic             active;
  lane_ctrl_t       cur_ctrl;
  logic             cur_exc;
  logic             cur_ertn;
  logic             cur_retire;
  logic [CNT_W-1:0] pend_cnt;
  logic             load;

  lane_pick #(.LANES(LANES)) u_lane_pick (
    .req    (pending_reg),
    .onehot (cur_onehot),
    .idx    (cur_idx),
    .any    (active)
  );

  assign cur_ctrl   = ctrl_reg[cur_idx];
  assign cur_exc    = active & cur_ctrl.exc;
  // Exception wins over ERTN on the same lane
  assign cur_ertn   = active & cur_ctrl.ertn & ~cur_ctrl.exc;
  assign cur_retire = active & ~cur_ctrl.exc;

  // Number of lanes still waiting to commit
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      pend_cnt = pend_cnt + CNT_W'(pending_reg[i]);
    end
  end

  // Accept a new bundle when empty, or when the last lane retires normally
  assign wb_allowin = ~active |
                      ((pend_cnt == CNT_W'(1)) & ~cur_ctrl.exc & ~cur_ctrl.ertn);
  assign load = mem_wb_valid & wb_allowin;

  // Pending mask, retire counter and idle-hold PC
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg    <= '0;
      retire_cnt_reg <= '0;
      last_pc_reg    <= '0;
    end else begin
      if (active) begin
        last_pc_reg <= pc_reg[cur_idx];
      end
      if (cur_retire) begin
        retire_cnt_reg <= retire_cnt_reg + 64'd1;
      end
      if (load) begin
        pending_reg <= mem_lane_valid;
      end else if (cur_exc || cur_ertn) begin
        pending_reg <= '0;
      end else if (active) begin
        pending_reg <= pending_reg & ~cur_onehot;
      end
    end
  end

  // Per-lane payload capture on bundle load
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        ctrl_reg[i]    <= '0;
        pc_reg[i]      <= '0;
        wdata_reg[i]   <= '0;
        badv_reg[i]    <= '0;
        wmask_reg[i]   <= '0;
        wvalue_reg[i]  <= '0;
        ecode_reg[i]   <= '0;
        esub_reg[i]    <= '0;
        csr_num_reg[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < LANES; i++) begin
        ctrl_reg[i] <= '{rf_we:    mem_rf_we[i],
                         csr_re:   mem_csr_re[i],
                         csr_we:   mem_csr_we[i],
                         exc:      mem_exc[i],
                         ertn:     mem_ertn[i],
                         rf_waddr: mem_rf_waddr[i*5 +: 5]};
        pc_reg[i]      <= mem_pc[i*DATA_W +: DATA_W];
        wdata_reg[i]   <= mem_rf_wdata[i*DATA_W +: DATA_W];
        badv_reg[i]    <= mem_badv[i*DATA_W +: DATA_W];
        wmask_reg[i]   <= mem_csr_wmask[i*DATA_W +: DATA_W];
        wvalue_reg[i]  <= mem_csr_wvalue[i*DATA_W +: DATA_W];
        ecode_reg[i]   <= mem_ecode[i*ECODE_W +: ECODE_W];
        esub_reg[i]    <= mem_esubcode[i*ESUB_W +: ESUB_W];
        csr_num_reg[i] <= mem_csr_num[i*CSR_NUM_W +: CSR_NUM_W];
      end
    end
  end

  // Commit outputs for the current lane; everything quiet while idle
  always_comb begin
    wb_rf_we    = 1'b0;
    wb_rf_waddr = '0;
    wb_rf_wdata = '0;
    csr_num     = '0;
    csr_we      = 1'b0;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    exc_signal  = cur_exc;
    ertn_signal = cur_ertn;
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_badv     = '0;
    wb_pc       = last_pc_reg;
    if (active) begin
      wb_pc       = pc_reg[cur_idx];
      wb_rf_we    = cur_ctrl.rf_we & ~cur_ctrl.exc;
      wb_rf_waddr = cur_ctrl.rf_waddr;
      wb_rf_wdata = cur_ctrl.csr_re ? csr_rvalue : wdata_reg[cur_idx];
      csr_num     = csr_num_reg[cur_idx];
      csr_we      = cur_ctrl.csr_we & ~cur_ctrl.exc;
      csr_wmask   = wmask_reg[cur_idx];
      csr_wvalue  = wvalue_reg[cur_idx];
      if (cur_ctrl.exc) begin
        wb_ecode    = ecode_reg[cur_idx];
        wb_esubcode = esub_reg[cur_idx];
        wb_badv     = badv_reg[cur_idx];
      end
    end
  end

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{wb_rf_we}};
  assign debug_wb_rf_wnum  = wb_rf_waddr;
  assign debug_wb_rf_wdata = wb_rf_wdata;
  assign retire_cnt        = retire_cnt_reg;

endmodule
